// File: rtl/sine_wave_sequencer.sv
// rtl/sine_wave_sequencer.sv - quarter-wave LUT sequencer producing a full signed sine wave
// Optional period counter output enabled by SINE_SEQ_PERIOD_COUNT_EN.
module sine_wave_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W:0]   sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
`ifdef SINE_SEQ_PERIOD_COUNT_EN
    output logic [15:0]       period_cnt,
`endif
    output logic              sign
);

    localparam logic [ADDR_W-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;

    state_t            state;
    state_t            nxt_q;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] nxt_cnt;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_sign;
    logic [DIV_W-1:0]  pc;
    logic [DIV_W-1:0]  div_q;
    logic              stop_pend;
    logic              upd;
    logic              tick;
    logic              wrap_end;

    assign tick     = (pc == div_q);
    assign wrap_end = (state == Q4) && (cnt == MAX);

    always_comb begin
        nxt_cnt = (cnt == MAX) ? '0 : cnt + 1'b1;
        nxt_q   = state;
        if (cnt == MAX) begin
            case (state)
                Q1:      nxt_q = Q2;
                Q2:      nxt_q = Q3;
                Q3:      nxt_q = Q4;
                default: nxt_q = Q1;
            endcase
        end
        // Q2/Q4 walk the quarter table backwards to mirror the waveform
        nxt_addr = (nxt_q == Q2 || nxt_q == Q4) ? MAX - nxt_cnt : nxt_cnt;
        nxt_sign = (nxt_q == Q3 || nxt_q == Q4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pc           <= '0;
            div_q        <= '0;
            stop_pend    <= 1'b0;
            upd          <= 1'b0;
            lut_addr     <= '0;
            sign         <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef SINE_SEQ_PERIOD_COUNT_EN
            period_cnt   <= '0;
`endif
        end else begin
            done         <= 1'b0;
            upd          <= 1'b0;
            sample_valid <= upd;
            // LUT data belongs to the address/sign registered on the previous edge
            if (upd) begin
                sample_out <= sign ? -{1'b0, lut_data} : {1'b0, lut_data};
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= Q1;
                        cnt       <= '0;
                        pc        <= '0;
                        div_q     <= div;
                        stop_pend <= 1'b0;
                        lut_addr  <= '0;
                        sign      <= 1'b0;
                        busy      <= 1'b1;
                        upd       <= 1'b1;
`ifdef SINE_SEQ_PERIOD_COUNT_EN
                        period_cnt <= '0;
`endif
                    end
                end
                default: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (tick) begin
                        pc  <= '0;
                        upd <= 1'b1;
`ifdef SINE_SEQ_PERIOD_COUNT_EN
                        if (wrap_end) begin
                            period_cnt <= period_cnt + 16'd1;
                        end
`endif
                        if (wrap_end && stop_pend) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            stop_pend <= 1'b0;
                            lut_addr  <= '0;
                            sign      <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state    <= nxt_q;
                            cnt      <= nxt_cnt;
                            lut_addr <= nxt_addr;
                            sign     <= nxt_sign;
                        end
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_wave_sequencer.sv
// tb/tb_sine_wave_sequencer.sv - randomized self-checking bench for sine_wave_sequencer
module tb_sine_wave_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] div;
    logic [5:0] lut_addr;
    logic [7:0] lut_data;
    logic [8:0] sample_out;
    logic       sample_valid;
    logic       busy;
    logic       done;
    logic       sign;
`ifdef SINE_SEQ_PERIOD_COUNT_EN
    logic [15:0] period_cnt;
`endif

    logic [7:0] lut [64];
    int n_checks = 0;
    int n_fail   = 0;
    int cur_n    = 0;

    always #5 clk = ~clk;
    assign lut_data = lut[lut_addr];

    sine_wave_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
`ifdef SINE_SEQ_PERIOD_COUNT_EN
        .period_cnt   (period_cnt),
`endif
        .sign         (sign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_n, obs, exp);
        end
    endtask

    // Wave position as plain arithmetic: step s lies in quadrant (s/64)%4
    function automatic int addr_of(input int step);
        int q = (step / 64) % 4;
        int i = step % 64;
        return (q % 2 == 1) ? 63 - i : i;
    endfunction

    function automatic int sign_of(input int step);
        return ((step / 64) % 4 >= 2) ? 1 : 0;
    endfunction

    function automatic int sample_of(input int a, input int sg);
        int m = lut[a];
        return sg ? ((512 - m) % 512) : m;
    endfunction

    // One run: start at edge 0 (with a stop that must be ignored), stray start at edge 3,
    // stop at edge ns (<=0: none), rst asserted at edge r (<0: none).
    task automatic run(input int d, input int ns, input int r);
        int p    = 256 * (d + 1);
        int nend = (ns > 0) ? (ns / p + 1) * p : 32'h3fff_ffff;
        int last = (r >= 0) ? r + 4 : nend + 4;
        int e_addr, e_sign, e_samp, e_valid, e_busy, e_done, e_pc, u;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            start = (n == 0) || (n == 3);
            stop  = (n == 0) || (n == ns);
            div   = (n == 0) ? 8'(d) : 8'($urandom);
            rst   = (n == r);
            @(posedge clk);
            #1;
            cur_n = n;
            if (r >= 0 && n >= r) begin
                e_addr = 0; e_sign = 0; e_samp = 0; e_valid = 0; e_busy = 0; e_done = 0; e_pc = 0;
            end else begin
                e_busy  = (n < nend);
                e_done  = (n == nend);
                e_addr  = (n < nend) ? addr_of(n / (d + 1)) : 0;
                e_sign  = (n < nend) ? sign_of(n / (d + 1)) : 0;
                e_valid = (n >= 1 && n <= nend + 1 && (n - 1) % (d + 1) == 0);
                e_pc    = ((n < nend) ? n : nend) / p;
                if (n == 0) begin
                    e_samp = 0;
                end else begin
                    u = ((n - 1) / (d + 1)) * (d + 1);
                    e_samp = (u >= nend) ? sample_of(0, 0)
                                         : sample_of(addr_of(u / (d + 1)), sign_of(u / (d + 1)));
                end
            end
            chk("lut_addr", 32'(lut_addr), 32'(e_addr));
            chk("sign", 32'(sign), 32'(e_sign));
            chk("sample_out", 32'(sample_out), 32'(e_samp));
            chk("sample_valid", 32'(sample_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
`ifdef SINE_SEQ_PERIOD_COUNT_EN
            chk("period_cnt", 32'(period_cnt), 32'(e_pc));
`endif
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int d, ns, r;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        div   = '0;
        for (int i = 0; i < 64; i++) lut[i] = 8'($urandom);
        lut[0]  = 8'd0;
        lut[10] = 8'd40;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 32'(lut_addr), 32'd0);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sign", 32'(sign), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(0, $urandom_range(66, 125), -1);
        run(3, $urandom_range(300, 1000), -1);
        d  = $urandom_range(0, 7);
        ns = $urandom_range(4, 2 * 256 * (d + 1) - 2);
        if (ns % (256 * (d + 1)) == 0) ns++;
        run(d, ns, -1);
        d = $urandom_range(1, 4);
        r = 128 * (d + 1) + $urandom_range(1, 64 * (d + 1) - 1);
        run(d, 0, r);
        run(0, 512 + $urandom_range(10, 200), -1);
        run($urandom_range(0, 2), $urandom_range(4, 200), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
